// File: rtl/read_capture_buffer_if.sv
// Read-return and consumer handshake bundle for read_capture_buffer.
// slave is the buffer's view; master is the side driving read beats and taking the head.
interface read_capture_buffer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic             read_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  read_data, read_valid, out_ready,
        output read_ready, out_data, out_valid
    );

    modport master (
        output read_data, read_valid, out_ready,
        input  read_ready, out_data, out_valid
    );
endinterface

// File: rtl/read_capture_buffer.sv
// Read-data capture stage: DEPTH-entry first-word-fall-through FIFO with a
// last-captured-word mirror and a sticky overflow flag.
module read_capture_buffer #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    read_capture_buffer_if.slave  bus,
    output logic [WIDTH-1:0]      last_data,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    input  logic                  clear
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;

    // Full/empty come from the occupancy count so pointer equality is never ambiguous.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.read_valid && !full;
    assign pop   = !empty && bus.out_ready;
    assign drop  = bus.read_valid && full;

    assign bus.read_ready = !full;
    assign bus.out_valid  = !empty;
    assign bus.out_data   = mem[rd_ptr];

    // Storage is deliberately not reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.read_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_data <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                last_data <= bus.read_data;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as clear keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   overflow <= 1'b0;
        else if (drop)  overflow <= 1'b1;
        else if (clear) overflow <= 1'b0;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset_n && bus.read_valid && $isunknown(bus.read_data))
            $error("read_capture_buffer: unknown read_data at %0t: %h", $time, bus.read_data);
    end
`endif
endmodule

// File: tb/tb_read_capture_buffer.sv
// Self-checking bench: queue model checked every cycle plus directed literal checks.
module tb_read_capture_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             clear;
    logic [WIDTH-1:0] last_data;
    logic [CW-1:0]    count;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    read_capture_buffer_if #(.WIDTH(WIDTH)) bus ();

    read_capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .last_data (last_data),
        .count     (count),
        .overflow  (overflow),
        .clear     (clear)
    );

    always #5 clock = ~clock;

    // Model: occupancy is the queue, full when it holds DEPTH words.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_last;
    logic             m_ovf;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_last = '0;
            m_ovf  = 1'b0;
        end else begin
            automatic bit was_full  = (q.size() == DEPTH);
            automatic bit was_valid = (q.size() != 0);
            if (was_valid && bus.out_ready) void'(q.pop_front());
            if (bus.read_valid && !was_full) begin
                q.push_back(bus.read_data);
                m_last = bus.read_data;
            end
            if (bus.read_valid && was_full) m_ovf = 1'b1;
            else if (clear)                 m_ovf = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("m_count",     64'(count),          64'(q.size()));
        chk("m_out_valid", 64'(bus.out_valid),  64'(q.size() != 0));
        chk("m_ready",     64'(bus.read_ready), 64'(q.size() != DEPTH));
        chk("m_overflow",  64'(overflow),       64'(m_ovf));
        chk("m_last",      64'(last_data),      64'(m_last));
        if (q.size() != 0 && !$isunknown(q[0]))
            chk("m_out_data", 64'(bus.out_data), 64'(q[0]));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push1(input logic [WIDTH-1:0] d);
        bus.read_valid = 1'b1;
        bus.read_data  = d;
        step();
        bus.read_valid = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_seq [4];
        exp_seq = '{32'h11, 32'h22, 32'h33, 32'h44};

        reset_n        = 1'b0;
        clear          = 1'b0;
        bus.read_valid = 1'b0;
        bus.read_data  = '0;
        bus.out_ready  = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.read_ready), 64'd1);
        reset_n = 1'b1;
        step();
        chk("rel_last", 64'(last_data), 64'd0);
        chk("rel_ovf",  64'(overflow), 64'd0);

        // Fill
        for (int i = 0; i < 4; i++) push1(exp_seq[i]);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_ready", 64'(bus.read_ready), 64'd0);
        chk("fill_last",  64'(last_data), 64'h44);

        // Overflow and clear
        push1(32'h55);
        chk("ovf_set",   64'(overflow), 64'd1);
        chk("ovf_last",  64'(last_data), 64'h44);
        chk("ovf_count", 64'(count), 64'd4);
        clear = 1'b1; step(); clear = 1'b0;
        chk("ovf_clear", 64'(overflow), 64'd0);
        clear = 1'b1; push1(32'h56); clear = 1'b0;
        chk("ovf_setwins", 64'(overflow), 64'd1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("ovf_clear2", 64'(overflow), 64'd0);

        // Drain; a beat offered while full alongside the first pop is still dropped
        bus.out_ready = 1'b1;
        chk("drain_head0", 64'(bus.out_data), 64'h11);
        push1(32'h66);
        chk("nobypass_count", 64'(count), 64'd3);
        chk("nobypass_ovf",   64'(overflow), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk("drain_valid", 64'(bus.out_valid), 64'd1);
            chk("drain_data",  64'(bus.out_data), 64'(exp_seq[i]));
            step();
        end
        chk("drain_empty", 64'(bus.out_valid), 64'd0);
        step();
        chk("underflow", 64'(count), 64'd0);
        clear = 1'b1; step(); clear = 1'b0;

        // Streaming through pointer wrap
        for (int i = 0; i < 10; i++) begin
            push1(WIDTH'(32'h100 + i));
            bus.read_valid = 1'b1;
            chk("stream_data",  64'(bus.out_data), 64'(32'h100 + i));
            chk("stream_count", 64'(count), 64'd1);
        end
        bus.read_valid = 1'b0;
        step();
        chk("stream_end", 64'(count), 64'd0);

        // Reset mid-stream
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push1(WIDTH'(32'h200 + i));
        chk("mid_count", 64'(count), 64'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step();
        push1(32'hAA);
        chk("post_rst_data",  64'(bus.out_data), 64'hAA);
        chk("post_rst_count", 64'(count), 64'd1);

        // Unknown data is still counted
        push1('x);
        chk("x_count", 64'(count), 64'd2);
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("x_drain", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule
